// File: rtl/neuron_sekvencer_pkg.sv
// neuron_sekvencer_pkg: shared FSM encoding and size defaults for the neuron sequencer
package neuron_sekvencer_pkg;
  localparam int BROJ_ULAZA_DEF  = 60;
  localparam int SIRINA_SUME_DEF = 22;
  localparam logic [2:0] MIRUJ   = 3'd0;
  localparam logic [2:0] DOHVAT  = 3'd1;
  localparam logic [2:0] MAC     = 3'd2;
  localparam logic [2:0] RAZLIKA = 3'd3;
  localparam logic [2:0] IZLAZ   = 3'd4;
endpackage

// File: rtl/neuron_sekvencer_if.sv
// neuron_sekvencer_if: start/sample/weight-memory/result bundle of the neuron sequencer
interface neuron_sekvencer_if
  import neuron_sekvencer_pkg::*;
#(
  parameter int BROJ_ULAZA = BROJ_ULAZA_DEF
);
  logic                      start;
  logic [16*BROJ_ULAZA-1:0]  uzorak;
  logic [5:0]                tezina_adr;
  logic [15:0]               tezina;
  logic                      busy;
  logic                      done;
  logic [15:0]               izlaz;
  logic                      predznak_izlaz;
  modport master (
    output start, uzorak, tezina,
    input  tezina_adr, busy, done, izlaz, predznak_izlaz
  );
  modport slave (
    input  start, uzorak, tezina,
    output tezina_adr, busy, done, izlaz, predznak_izlaz
  );
endinterface

// File: rtl/neuron_sekvencer_aritmetika.sv
// neuron_sekvencer_aritmetika: combinational multiplier and sigmoid approximation
module mnozenje (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] p
);
  logic [30:0] pun;
  // a is sign-magnitude Q1.15, so only its magnitude enters the product
  assign pun = {16'b0, a[14:0]} * {15'b0, b};
  assign p   = pun[30:15];
endmodule

module Sigmoid_LUT #(
  parameter int W = 22
) (
  input  logic [W-1:0] suma,
  input  logic         predznak,
  output logic [15:0]  y
);
  logic [W-1:0] s8;
  logic [14:0]  m;
  // piecewise-linear around 0.5 (16'h8000), slope 1/256, saturating
  assign s8 = suma >> 8;
  assign m  = (s8 > W'(15'h7FFF)) ? 15'h7FFF : s8[14:0];
  assign y  = predznak ? 16'h8000 - {1'b0, m} : 16'h8000 + {1'b0, m};
endmodule

// File: rtl/neuron_sekvencer.sv
// neuron_sekvencer: sequences one sign-magnitude MAC pass over latched samples and maps the sum through a sigmoid
module neuron_sekvencer
  import neuron_sekvencer_pkg::*;
#(
  parameter int BROJ_ULAZA  = BROJ_ULAZA_DEF,
  parameter int SIRINA_SUME = SIRINA_SUME_DEF
) (
  input logic               clk,
  input logic               rst,
  neuron_sekvencer_if.slave bus
);
  localparam logic [5:0] K_MAX = 6'(BROJ_ULAZA - 1);
  logic [2:0]               stanje;
  logic [5:0]               k;
  logic [16*BROJ_ULAZA-1:0] uzorak_r;
  logic [SIRINA_SUME-1:0]   p_suma, n_suma, suma, proizvod_w;
  logic                     predznak;
  logic [15:0]              element, proizvod, sigmoid;
  assign element    = uzorak_r[16*k +: 16];
  assign proizvod_w = {{(SIRINA_SUME-16){1'b0}}, proizvod};
  mnozenje u_mnozenje (
    .a (bus.tezina),
    .b (element),
    .p (proizvod)
  );
  Sigmoid_LUT #(.W(SIRINA_SUME)) u_sigmoid (
    .suma     (suma),
    .predznak (predznak),
    .y        (sigmoid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      stanje             <= MIRUJ;
      k                  <= '0;
      uzorak_r           <= '0;
      p_suma             <= '0;
      n_suma             <= '0;
      suma               <= '0;
      predznak           <= 1'b0;
      bus.tezina_adr     <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.izlaz          <= '0;
      bus.predznak_izlaz <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (stanje)
        MIRUJ: if (bus.start) begin
          uzorak_r       <= bus.uzorak;
          p_suma         <= '0;
          n_suma         <= '0;
          bus.tezina_adr <= '0;
          bus.busy       <= 1'b1;
          stanje         <= DOHVAT;
        end
        DOHVAT: begin
          bus.tezina_adr <= 6'd1;
          k              <= '0;
          stanje         <= MAC;
        end
        MAC: begin
          if (bus.tezina[15]) n_suma <= n_suma + proizvod_w;
          else                p_suma <= p_suma + proizvod_w;
          // the address runs one ahead of k to cover the memory read latency
          bus.tezina_adr <= (bus.tezina_adr == K_MAX) ? K_MAX : bus.tezina_adr + 6'd1;
          k              <= (k == K_MAX) ? k : k + 6'd1;
          stanje         <= (k == K_MAX) ? RAZLIKA : MAC;
        end
        RAZLIKA: begin
          suma     <= (p_suma > n_suma) ? p_suma - n_suma : n_suma - p_suma;
          predznak <= !(p_suma > n_suma);
          stanje   <= IZLAZ;
        end
        IZLAZ: begin
          bus.izlaz          <= sigmoid;
          bus.predznak_izlaz <= predznak;
          bus.done           <= 1'b1;
          bus.busy           <= 1'b0;
          stanje             <= MIRUJ;
        end
        default: stanje <= MIRUJ;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_sekvencer.sv
// tb_neuron_sekvencer: directed vector table plus multi-cycle corner sequences for neuron_sekvencer
module tb_neuron_sekvencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] wmem [60];
  neuron_sekvencer_if #(.BROJ_ULAZA(60)) bus ();
  neuron_sekvencer #(.BROJ_ULAZA(60), .SIRINA_SUME(22)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) bus.tezina <= (bus.tezina_adr < 6'd60) ? wmem[bus.tezina_adr] : 16'h0;
  typedef struct {
    int          wp;
    int          sp;
    logic [15:0] iz;
    logic        pz;
  } vec_t;
  vec_t tbl [7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic set_pat(input int wp, input int sp);
    for (int k = 0; k < 60; k++) begin
      wmem[k] = wp == 0 ? 16'h1234 : wp == 1 ? ((k % 2 == 1) ? 16'h9000 : 16'h1000) :
                wp == 2 ? 16'h7FFF : wp == 3 ? 16'hFFFF : wp == 4 ? 16'h4000 :
                (k < 30 ? 16'h4000 : 16'hC000);
      bus.uzorak[16*k +: 16] = sp == 0 ? 16'h0 : sp == 1 ? 16'h4000 : sp == 2 ? 16'hFFFF :
                               sp == 3 ? 16'(k * 256) : (k < 30 ? 16'hFFFF : 16'h0);
    end
  endtask
  task automatic run(input string nm, input logic [15:0] iz, input logic pz);
    int n;
    int bad;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    bad = 0;
    while (!bus.done && n < 100) begin
      if (bus.tezina_adr !== 6'(n < 59 ? n : 59) || bus.busy !== 1'b1) bad++;
      @(posedge clk);
      #1 n++;
    end
    chk({nm, "_latency"}, n, 63);
    chk({nm, "_adr_busy_seq"}, bad, 0);
    chk({nm, "_izlaz"}, bus.izlaz, iz);
    chk({nm, "_predznak"}, bus.predznak_izlaz, pz);
    chk({nm, "_busy_at_done"}, bus.busy, 0);
    @(posedge clk);
    #1 chk({nm, "_done_width"}, bus.done, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    int bad;
    int pulses;
    tbl[0] = '{0, 0, 16'h8000, 1'b1};
    tbl[1] = '{1, 1, 16'h8000, 1'b1};
    tbl[2] = '{2, 2, 16'hBBFF, 1'b0};
    tbl[3] = '{3, 2, 16'h4401, 1'b1};
    tbl[4] = '{4, 3, 16'h8375, 1'b0};
    tbl[5] = '{5, 3, 16'h7E3E, 1'b1};
    tbl[6] = '{2, 4, 16'h9DFF, 1'b0};
    bus.start = 1'b0;
    bus.uzorak = '0;
    set_pat(0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_izlaz", bus.izlaz, 0);
    chk("rst_predznak", bus.predznak_izlaz, 0);
    chk("rst_adr", bus.tezina_adr, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_pat(tbl[i].wp, tbl[i].sp);
      run($sformatf("vec%0d", i), tbl[i].iz, tbl[i].pz);
    end
    // start pulse mid-run and sample change after acceptance must not matter
    set_pat(5, 3);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk);
      #1 n++;
      if (n == 12) bus.start = 1'b1;
      if (n == 13) bus.start = 1'b0;
      if (n == 22) set_pat(5, 2);
    end
    chk("ignore_latency", n, 63);
    chk("ignore_izlaz", bus.izlaz, 16'h7E3E);
    chk("ignore_predznak", bus.predznak_izlaz, 1);
    pulses = 0;
    bad = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
      if (bus.busy) bad++;
    end
    chk("ignore_no_second_run", pulses, 0);
    chk("ignore_idle_busy", bad, 0);
    // back-to-back with start held high
    set_pat(2, 2);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bad = 0;
    pulses = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (bus.done !== (c % 64 == 63)) bad++;
      if (bus.done) begin
        pulses++;
        if (bus.izlaz !== 16'hBBFF) bad++;
      end
    end
    bus.start = 1'b0;
    chk("b2b_done_pattern", bad, 0);
    chk("b2b_pulses", pulses, 3);
    n = 0;
    while (bus.busy && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("b2b_drain", bus.busy, 0);
    // reset in the middle of MAC
    set_pat(4, 3);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (31) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_izlaz", bus.izlaz, 0);
    chk("midrst_adr", bus.tezina_adr, 0);
    chk("midrst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    run("after_rst", 16'h8375, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/neuron_sekvencer.md
NEURON_SEKVENCER -- requirements
Module: neuron_sekvencer

Interface
REQ-001 SHALL have parameter BROJ_ULAZA, default 60, number of sample/weight pairs per evaluation.
REQ-002 SHALL have parameter SIRINA_SUME, default 22, accumulator width in bits.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request one neuron evaluation; sampled only in MIRUJ.
REQ-007 uzorak  input  16*BROJ_ULAZA  sample vector; element k occupies bits [16k+15:16k].
REQ-008 tezina_adr  output  6  registered weight-memory address.
REQ-009 tezina  input  16  sign-magnitude weight from synchronous memory, valid the cycle after tezina_adr is captured; bit 15 is the sign (1 = negative).
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 done  output  1  one-cycle pulse when izlaz is updated.
REQ-012 izlaz  output  16  registered sigmoid probability; held between evaluations.
REQ-013 predznak_izlaz  output  1  registered sign of the final sum (1 = negative or zero).

Function
REQ-014 FSM SHALL have states MIRUJ, DOHVAT, MAC, RAZLIKA and IZLAZ.
REQ-015 MIRUJ with start=1: latch uzorak into an internal register, clear P_suma and N_suma, set tezina_adr<=0, set busy<=1, go to DOHVAT.
REQ-016 DOHVAT: tezina_adr<=1, k<=0, go to MAC (single cycle).
REQ-017 MAC, each cycle: multiply tezina by latched element k through one mnozenje instance; the unsigned 16-bit product is added to N_suma if tezina[15]=1, else to P_suma.
REQ-018 MAC: k and tezina_adr SHALL increment each cycle; after k=BROJ_ULAZA-1 the FSM goes to RAZLIKA; tezina_adr SHALL not advance past BROJ_ULAZA-1.
REQ-019 RAZLIKA: if P_suma>N_suma then suma<=P_suma-N_suma and predznak<=0; otherwise suma<=N_suma-P_suma and predznak<=1. Equal sums give suma 0 and predznak 1.
REQ-020 IZLAZ: izlaz<=Sigmoid_LUT(suma,predznak), predznak_izlaz<=predznak, done<=1, busy<=0, go to MIRUJ.
REQ-021 Latency: done SHALL be high in the cycle after the 63rd rising edge following the edge that sampled start (BROJ_ULAZA+3 edges).
REQ-022 With start held high, back-to-back evaluations SHALL run with a 64-cycle period.
REQ-023 start outside MIRUJ SHALL be ignored; uzorak changes after acceptance SHALL not affect the result.
REQ-024 Widths: 60*65535 < 2^22, so accumulators SHALL not saturate or wrap; all sums unsigned SIRINA_SUME bits.

Reset
REQ-025 rst SHALL force MIRUJ and set busy=0, done=0, izlaz=0, predznak_izlaz=0, tezina_adr=0, sums=0, k=0.
REQ-026 rst in any state, including mid-MAC, SHALL abort the evaluation without a done pulse; rst has priority over start.

Structure
REQ-027 State encoding, BROJ_ULAZA and SIRINA_SUME defaults SHALL live in the shared neuron package.
REQ-028 SHALL instantiate exactly one mnozenje and one Sigmoid_LUT (both combinational); the FSM/counter SHALL be in-module with no other sub-module.

Verification
REQ-029 All samples 0 -> suma 0, predznak_izlaz 1, izlaz = Sigmoid_LUT(0,1), done exactly 63 edges after start.
REQ-030 Weights alternating 16'h1000/16'h9000, all samples 16'h4000 -> P_suma=N_suma, suma 0, predznak_izlaz 1.
REQ-031 All weights 16'h7FFF, all samples 16'hFFFF -> suma = 60*mnozenje(16'h7FFF,16'hFFFF) with no wrap, predznak_izlaz 0.
REQ-032 start held high for 200 cycles -> done pulses exactly every 64 cycles, each one cycle wide; tezina_adr sequence 0..59 each run.
REQ-033 start pulsed at k=10 and uzorak changed at k=20 -> no effect; result equals the first run's golden value.
REQ-034 rst at k=30 -> next cycle busy 0, izlaz 0, tezina_adr 0, no done; a following start gives the correct result.
